intr_ctrl: RTL
==============

INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameter TIMER_DIV, default 1, SHALL set the clk cycles per mtime increment (legal range 1..65535).
REQ-002 Parameter XLEN, default 64 (taken from eei), SHALL set the CSR/timer data width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 ext_irq  in  1  SHALL be the external interrupt level, already synchronous to clk.
REQ-006 sw_irq_set / sw_irq_clr  in  1 each  SHALL be single-cycle pulses that set or clear MSIP.
REQ-007 csr_we  in  1;  csr_addr  in  12;  csr_wdata  in  XLEN  SHALL carry the final masked CSR write.
REQ-008 csr_rdata  out  XLEN  SHALL return the combinational read of csr_addr.
REQ-009 tmr_we  in  1;  tmr_wdata  in  XLEN  SHALL write mtimecmp.
REQ-010 irq_req  out  1;  irq_cause  out  XLEN  SHALL form the interrupt request to the trap unit.
REQ-011 irq_ack  in  1  SHALL indicate the trap unit took the interrupt this cycle.
REQ-012 mret  in  1  SHALL indicate a retiring MRET.
REQ-013 mtime  out  XLEN  SHALL expose the timer counter.

Function
REQ-014 Owned CSRs: MSTATUS 0x300 (bits MIE[3], MPIE[7] only, others read 0), MIE 0x304 (MEIE[11], MTIE[7], MSIE[3]), MIP 0x344 (MEIP[11], MTIP[7], MSIP[3]; read-only, writes ignored); any other address SHALL read 0.
REQ-015 mip SHALL be registered each cycle: MEIP<=ext_irq, MTIP<=(mtime>=mtimecmp, unsigned), MSIP set by sw_irq_set, cleared by sw_irq_clr; set and clr together SHALL clear.
REQ-016 pending = mip & mie; a source is eligible only if pending and MSTATUS.MIE=1.
REQ-017 Priority SHALL be MEI > MSI > MTI; irq_cause = {1'b1, zeros, code} with code 11, 3, 7 respectively.
REQ-018 FSM states IDLE, REQ, HANDLER; reset state IDLE.
REQ-019 IDLE->REQ when any source eligible; the winning cause SHALL latch on that transition.
REQ-020 In REQ, irq_req=1 and irq_cause SHALL stay stable until irq_ack, even if the source drops or is disabled (no retraction).
REQ-021 REQ->HANDLER on irq_ack; same edge: MPIE<=MIE, MIE<=0.
REQ-022 HANDLER->IDLE on mret; same edge: MIE<=MPIE, MPIE<=1.
REQ-023 mret in IDLE or REQ SHALL still perform the MIE/MPIE restore but SHALL NOT change FSM state; irq_ack outside REQ SHALL be ignored.
REQ-024 csr_we to MSTATUS on the same edge as irq_ack or mret: the hardware update of MIE/MPIE SHALL win.
REQ-025 Latency: ext_irq rising at edge k with MEIE=MIE=1 in IDLE SHALL give irq_req=1 after edge k+2 (mip register, then FSM).
REQ-026 mtime SHALL increment by 1 every TIMER_DIV cycles via a prescaler counter, wrapping 2^XLEN-1 -> 0; tmr_we SHALL NOT reset the prescaler.
REQ-027 irq_req SHALL be 0 in IDLE and HANDLER; irq_cause SHALL be 0 when irq_req=0.

Reset
REQ-028 On rst=1 at a clock edge: FSM=IDLE, irq_req=0, irq_cause=0, mstatus=0, mie=0, mip=0, mtime=0, prescaler=0, mtimecmp=all ones.
REQ-029 rst asserted in REQ or HANDLER SHALL abandon the request with no ack/mret required; rst SHALL override all same-cycle inputs.

Configuration
REQ-030 Macro INTR_CTRL_TIMER_EN defined: timer, prescaler, mtimecmp and MTIP/MTIE implemented as above.
REQ-031 Macro undefined: no timer logic; mtime=0, MTIP=0, MTIE reads 0 and is not writable, tmr_we ignored; MEI/MSI unaffected.

Verification
REQ-032 MIE=1, MEIE=1, pulse ext_irq high -> irq_req=1 two edges later, irq_cause=0x8000_0000_0000_000B, held until irq_ack, then MIE=0, MPIE=1.
REQ-033 MSIE=MEIE=1, sw_irq_set and ext_irq same cycle -> cause code 11; after ack+mret with MSIP still set -> second request with code 3.
REQ-034 TIMER_EN, TIMER_DIV=4, mtimecmp=10, MTIE=MIE=1 -> MTIP set when mtime=10 (~40 cycles), cause code 7; write mtimecmp=all ones -> MTIP clears next edge.
REQ-035 In REQ, deassert ext_irq and clear MEIE -> irq_req and cause unchanged until irq_ack.
REQ-036 rst=1 while in HANDLER -> next cycle IDLE, mstatus=0, mtime=0, mtimecmp=all ones, irq_req=0.
REQ-037 Macro undefined: write MIE=0x888 -> reads 0x808; tmr_we ignored, mtime stays 0.

Source files
------------

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - machine-mode interrupt controller (MEI/MSI/MTI), timer gated by INTR_CTRL_TIMER_EN
module intr_ctrl #(
    parameter int unsigned TIMER_DIV = 1,
    parameter int unsigned XLEN      = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ext_irq,
    input  logic            sw_irq_set,
    input  logic            sw_irq_clr,
    input  logic            csr_we,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    input  logic            tmr_we,
    input  logic [XLEN-1:0] tmr_wdata,
    output logic            irq_req,
    output logic [XLEN-1:0] irq_cause,
    input  logic            irq_ack,
    input  logic            mret,
    output logic [XLEN-1:0] mtime
);

    typedef enum logic [1:0] {IDLE, REQ, HANDLER} state_e;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

    localparam logic [XLEN-1:0] CAUSE_MEI = {1'b1, {(XLEN-5){1'b0}}, 4'd11};
    localparam logic [XLEN-1:0] CAUSE_MSI = {1'b1, {(XLEN-5){1'b0}}, 4'd3};
    localparam logic [XLEN-1:0] CAUSE_MTI = {1'b1, {(XLEN-5){1'b0}}, 4'd7};

    state_e          state_q, state_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic            mstatus_mie_q, mstatus_mie_d;
    logic            mstatus_mpie_q, mstatus_mpie_d;
    logic            meie_q, meie_d;
    logic            msie_q, msie_d;
    logic            meip_q, meip_d;
    logic            msip_q, msip_d;
    logic            mtie_bit;
    logic            mtip_bit;
    logic            unused_bits;

    assign unused_bits = ^{csr_wdata[XLEN-1:12], csr_wdata[10:8], csr_wdata[6:4], csr_wdata[2:0]};

`ifdef INTR_CTRL_TIMER_EN
    localparam logic [15:0] DIV_MAX = 16'(TIMER_DIV - 1);

    logic [15:0]     presc_q, presc_d;
    logic [XLEN-1:0] mtime_q, mtime_d;
    logic [XLEN-1:0] mtimecmp_q, mtimecmp_d;
    logic            mtie_q, mtie_d;
    logic            mtip_q, mtip_d;

    // tmr_we only touches mtimecmp; the prescaler free-runs regardless
    always_comb begin
        presc_d    = presc_q + 16'd1;
        mtime_d    = mtime_q;
        if (presc_q == DIV_MAX) begin
            presc_d = '0;
            mtime_d = mtime_q + XLEN'(1);
        end
        mtimecmp_d = tmr_we ? tmr_wdata : mtimecmp_q;
        mtip_d     = (mtime_q >= mtimecmp_q);
        mtie_d     = (csr_we && csr_addr == ADDR_MIE) ? csr_wdata[7] : mtie_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            mtie_q     <= 1'b0;
            mtip_q     <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            mtie_q     <= mtie_d;
            mtip_q     <= mtip_d;
        end
    end

    assign mtime    = mtime_q;
    assign mtie_bit = mtie_q;
    assign mtip_bit = mtip_q;
`else
    logic unused_timer;

    assign unused_timer = ^{tmr_we, tmr_wdata, 16'(TIMER_DIV)};
    assign mtime        = '0;
    assign mtie_bit     = 1'b0;
    assign mtip_bit     = 1'b0;
`endif

    logic pend_mei, pend_msi, pend_mti;

    assign pend_mei = meip_q & meie_q   & mstatus_mie_q;
    assign pend_msi = msip_q & msie_q   & mstatus_mie_q;
    assign pend_mti = mtip_bit & mtie_bit & mstatus_mie_q;

    always_comb begin
        state_d        = state_q;
        cause_d        = cause_q;
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        meie_d         = meie_q;
        msie_d         = msie_q;
        meip_d         = ext_irq;
        msip_d         = msip_q;

        if (sw_irq_clr)      msip_d = 1'b0;
        else if (sw_irq_set) msip_d = 1'b1;

        if (csr_we && csr_addr == ADDR_MSTATUS) begin
            mstatus_mie_d  = csr_wdata[3];
            mstatus_mpie_d = csr_wdata[7];
        end
        if (csr_we && csr_addr == ADDR_MIE) begin
            meie_d = csr_wdata[11];
            msie_d = csr_wdata[3];
        end

        // Hardware MIE/MPIE updates are applied last so they override CSR writes
        if (mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pend_mei) begin
                    state_d = REQ;
                    cause_d = CAUSE_MEI;
                end else if (pend_msi) begin
                    state_d = REQ;
                    cause_d = CAUSE_MSI;
                end else if (pend_mti) begin
                    state_d = REQ;
                    cause_d = CAUSE_MTI;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_d        = HANDLER;
                    mstatus_mpie_d = mstatus_mie_q;
                    mstatus_mie_d  = 1'b0;
                end
            end
            HANDLER: begin
                if (mret) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cause_q        <= '0;
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            meie_q         <= 1'b0;
            msie_q         <= 1'b0;
            meip_q         <= 1'b0;
            msip_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cause_q        <= cause_d;
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            meie_q         <= meie_d;
            msie_q         <= msie_d;
            meip_q         <= meip_d;
            msip_q         <= msip_d;
        end
    end

    assign irq_req   = (state_q == REQ);
    assign irq_cause = irq_req ? cause_q : '0;

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            ADDR_MSTATUS: begin
                csr_rdata[3] = mstatus_mie_q;
                csr_rdata[7] = mstatus_mpie_q;
            end
            ADDR_MIE: begin
                csr_rdata[11] = meie_q;
                csr_rdata[7]  = mtie_bit;
                csr_rdata[3]  = msie_q;
            end
            ADDR_MIP: begin
                csr_rdata[11] = meip_q;
                csr_rdata[7]  = mtip_bit;
                csr_rdata[3]  = msip_q;
            end
            default: csr_rdata = '0;
        endcase
    end

endmodule
